// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Posted-write FIFO between EX/MEM and the data memory write
//                port. Buffers word/byte stores in program order, retires one
//                store per granted cycle, and stalls loads whose byte range
//                overlaps any pending store.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    // Store request from EX/MEM
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic             st_byte,
    output logic             st_ready,

    // Load hazard check in MEM
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic             ld_byte,
    output logic             ld_stall,

    // Memory write port
    input  logic             drain_en,
    output logic             mem_write_en,
    output logic [31:0]      mem_write_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_as_byte,

    // Status
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   c_full    = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   c_cnt_one = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] c_ptr_one = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [32:0]      c_word_ext = 33'd3;
    localparam logic [32:0]      c_byte_ext = 33'd0;

    // Entry storage
    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_byte;
    logic [DEPTH-1:0] r_valid;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [DEPTH-1:0] w_hit;
    logic [32:0]      w_ld_lo;
    logic [32:0]      w_ld_hi;

    // Handshake and status decode. A full buffer never accepts, even when
    // the head is popping in the same cycle.
    assign w_empty  = (r_count == '0);
    assign st_ready = (r_count != c_full);
    assign w_push   = st_valid && st_ready;
    assign w_pop    = drain_en && !w_empty;

    assign empty    = w_empty;
    assign count    = r_count;

    // Head entry drives the memory port; fields hold (not X) while empty.
    assign mem_write_en   = w_pop;
    assign mem_write_addr = r_addr[r_rd_ptr];
    assign mem_write_data = r_data[r_rd_ptr];
    assign mem_as_byte    = r_byte[r_rd_ptr];

    // Load byte range, widened to 33 bits so the top-of-memory word does
    // not wrap around to address 0.
    assign w_ld_lo = {1'b0, ld_addr};
    assign w_ld_hi = w_ld_lo + (ld_byte ? c_byte_ext : c_word_ext);

    // Per-entry overlap compare against the load range.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
            logic [32:0] w_s_lo;
            logic [32:0] w_s_hi;
            assign w_s_lo   = {1'b0, r_addr[i]};
            assign w_s_hi   = w_s_lo + (r_byte[i] ? c_byte_ext : c_word_ext);
            assign w_hit[i] = r_valid[i] && (w_s_lo <= w_ld_hi) && (w_ld_lo <= w_s_hi);
        end
    endgenerate

    // Compare uses only entries present before this edge, so a store pushed
    // alongside the load never stalls it.
    assign ld_stall = ld_valid && (|w_hit);

    // Entry payload and valid-bit update on push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_byte  <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_addr[r_wr_ptr]  <= st_addr;
                r_data[r_wr_ptr]  <= st_data;
                r_byte[r_wr_ptr]  <= st_byte;
                r_valid[r_wr_ptr] <= 1'b1;
            end
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Directed self-checking bench for store_buffer with a
//                scoreboard of expected memory writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_byte;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_byte;
    logic        ld_stall;
    logic        drain_en;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_as_byte;
    logic        empty;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_byte        (st_byte),
        .st_ready       (st_ready),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_byte        (ld_byte),
        .ld_stall       (ld_stall),
        .drain_en       (drain_en),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_as_byte    (mem_as_byte),
        .empty          (empty),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Memory-side monitor: every write must match the oldest expected store.
    always @(negedge clk) begin
        if (rst_n && mem_write_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {1'b0, mem_write_addr}, 33'h1_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", {1'b0, mem_write_addr}, {1'b0, e.a});
                chk("wr_data", {1'b0, mem_write_data}, {1'b0, e.d});
                chk("wr_byte", {32'b0, mem_as_byte}, {32'b0, e.b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one store; record it as expected only if the DUT accepts it.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic b);
        logic acc;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_byte  = b;
        @(negedge clk);
        acc = st_ready;
        @(posedge clk);
        if (acc) sb.push_back('{a: a, d: d, b: b});
        #1;
        st_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic b, input logic exp);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_byte  = b;
        @(negedge clk);
        chk(tag, {32'b0, ld_stall}, {32'b0, exp});
        tick();
        ld_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_byte  = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_byte  = 1'b0;
        drain_en = 1'b0;

        // Power-on reset state
        #2;
        chk("rst_count", {30'b0, count}, 33'd0);
        chk("rst_empty", {32'b0, empty}, 33'd1);
        chk("rst_ready", {32'b0, st_ready}, 33'd1);
        chk("rst_ld_stall", {32'b0, ld_stall}, 33'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-stream discards pending stores
        do_store(32'h100, 32'h1111_1111, 1'b0);
        do_store(32'h104, 32'h2222_2222, 1'b0);
        do_store(32'h108, 32'h3333_3333, 1'b1);
        @(negedge clk);
        chk("pre_rst_count", {30'b0, count}, 33'd3);
        tick();
        rst_n    = 1'b0;
        drain_en = 1'b1;
        #1;
        chk("mid_rst_count", {30'b0, count}, 33'd0);
        chk("mid_rst_wen", {32'b0, mem_write_en}, 33'd0);
        tick();
        tick();
        chk("mid_rst_empty", {32'b0, empty}, 33'd1);
        chk("mid_rst_ready", {32'b0, st_ready}, 33'd1);
        sb.delete();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_empty", {32'b0, empty}, 33'd1);
        drain_en = 1'b0;

        // Word store then drain
        do_store(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("sw_count", {30'b0, count}, 33'd1);
        tick();
        drain_en = 1'b1;
        @(negedge clk);
        chk("sw_wen", {32'b0, mem_write_en}, 33'd1);
        tick();
        drain_en = 1'b0;
        @(negedge clk);
        chk("sw_empty", {32'b0, empty}, 33'd1);
        chk("sw_wen_off", {32'b0, mem_write_en}, 33'd0);
        tick();

        // Fill to full, fifth store ignored, then drain in order
        for (int i = 0; i < 4; i++) begin
            do_store(32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
        end
        @(negedge clk);
        chk("full_count", {30'b0, count}, 33'd4);
        chk("full_ready", {32'b0, st_ready}, 33'd0);
        do_store(32'h300, 32'hBAD0_BAD0, 1'b0);
        @(negedge clk);
        chk("full_ignore_count", {30'b0, count}, 33'd4);
        tick();
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_count", {30'b0, count}, 33'(4 - i));
            chk("drain_wen", {32'b0, mem_write_en}, 33'd1);
            tick();
        end
        drain_en = 1'b0;
        @(negedge clk);
        chk("drain_empty", {32'b0, empty}, 33'd1);
        chk("drain_sb_done", 33'(sb.size()), 33'd0);
        tick();

        // Overlap stall against a pending byte store
        do_store(32'h0000_0013, 32'h0000_00AB, 1'b1);
        do_load("ovl_lw_10", 32'h10, 1'b0, 1'b1);
        do_load("ovl_lw_14", 32'h14, 1'b0, 1'b0);
        do_load("ovl_lb_12", 32'h12, 1'b1, 1'b0);
        ld_valid = 1'b1;
        ld_addr  = 32'h13;
        ld_byte  = 1'b1;
        @(negedge clk);
        chk("ovl_lb_13", {32'b0, ld_stall}, 33'd1);
        tick();
        drain_en = 1'b1;
        @(negedge clk);
        chk("ovl_drain_cycle", {32'b0, ld_stall}, 33'd1);
        tick();
        drain_en = 1'b0;
        @(negedge clk);
        chk("ovl_release", {32'b0, ld_stall}, 33'd0);
        tick();
        ld_valid = 1'b0;

        // Load and store together on an empty buffer: load sees older stores only
        st_valid = 1'b1;
        st_addr  = 32'h40;
        st_data  = 32'h4040_4040;
        st_byte  = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h40;
        ld_byte  = 1'b0;
        @(negedge clk);
        chk("same_cycle_ld", {32'b0, ld_stall}, 33'd0);
        @(posedge clk);
        sb.push_back('{a: 32'h40, d: 32'h4040_4040, b: 1'b0});
        #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("next_cycle_ld", {32'b0, ld_stall}, 33'd1);
        tick();
        ld_valid = 1'b0;
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;

        // Push and pop in the same cycle, pointers wrap
        do_store(32'h500, 32'h5000_0000, 1'b0);
        do_store(32'h501, 32'h5000_0001, 1'b1);
        @(negedge clk);
        chk("pp_start_count", {30'b0, count}, 33'd2);
        tick();
        drain_en = 1'b1;
        st_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic acc;
            st_addr = 32'h600 + 32'(i * 4);
            st_data = 32'h6000_0000 + 32'(i);
            st_byte = 1'b0;
            @(negedge clk);
            acc = st_ready;
            chk("pp_count", {30'b0, count}, 33'd2);
            @(posedge clk);
            if (acc) sb.push_back('{a: st_addr, d: st_data, b: 1'b0});
            #1;
        end
        st_valid = 1'b0;
        @(negedge clk);
        chk("pp_end_count", {30'b0, count}, 33'd2);
        tick();
        tick();
        drain_en = 1'b0;
        @(negedge clk);
        chk("pp_empty", {32'b0, empty}, 33'd1);
        chk("pp_sb_done", 33'(sb.size()), 33'd0);
        tick();

        // Top-of-memory word does not alias address 0
        do_store(32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b0);
        do_load("wrap_lw_0", 32'h0000_0000, 1'b0, 1'b0);
        do_load("wrap_lb_ff", 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_load("wrap_lw_fd", 32'hFFFF_FFFD, 1'b0, 1'b1);
        do_load("wrap_lw_f8", 32'hFFFF_FFF8, 1'b0, 1'b0);
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        @(negedge clk);
        chk("final_empty", {32'b0, empty}, 33'd1);
        chk("final_sb_done", 33'(sb.size()), 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
